// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator
//   Accumulates a frame of {cout,sum} samples from the 4-bit adder stage into a
//   wider register and hands the frame total downstream over valid/ready.
//   Optional build macro: ACC_SATURATE_EN
//     defined   -> on overflow the accumulator clamps to all-ones for the rest of the frame
//     undefined -> the accumulator wraps modulo 2^ACC_W
//   out_ovf is sticky for the frame in both builds.
module adder_result_accumulator #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_cout,
  input  logic [CNT_W-1:0] frame_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic             ovf;

  logic [ACC_W-1:0] value;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] eff_len;
  logic             accept;
  logic             last;
  logic             res_accept;

  // Sample arithmetic, frame-length selection and handshake qualifiers.
  always_comb begin
    value      = ACC_W'({in_cout, in_sum});
    sum_ext    = {1'b0, acc} + {1'b0, value};
    carry      = sum_ext[ACC_W];
    cnt_inc    = cnt + CNT_W'(1);
    if (cnt == '0) begin
      eff_len = (frame_len == '0) ? CNT_W'(1) : frame_len;
    end else begin
      eff_len = len_q;
    end
    accept     = (state == ACCUM) && in_valid;
    last       = (cnt_inc == eff_len);
    res_accept = (state == HOLD) && out_ready;
  end

  // State register; reset discards any partial or pending frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: close the frame on its final sample, reopen once the result is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && last) state_nxt = HOLD;
      HOLD:  if (res_accept)     state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulator datapath: add on accept, clear when the result is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      if (cnt == '0) begin
        len_q <= eff_len;
      end
`ifdef ACC_SATURATE_EN
      if (ovf || carry) begin
        acc <= '1;
      end else begin
        acc <= sum_ext[ACC_W-1:0];
      end
`else
      acc <= sum_ext[ACC_W-1:0];
`endif
      ovf <= ovf | carry;
      cnt <= cnt_inc;
    end else if (res_accept) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

  // Outputs are decoded straight from registered state so they hold steady in HOLD.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
    out_acc   = acc;
    out_ovf   = ovf;
    out_count = cnt;
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb_adder_result_accumulator
//   Directed bench for adder_result_accumulator built with ACC_W=6 so that
//   overflow is reachable with a few samples. Expected totals are hand-computed.
module tb_adder_result_accumulator;

  localparam int IN_W  = 4;
  localparam int ACC_W = 6;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic             in_cout;
  logic [CNT_W-1:0] frame_len;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int vectors;
  int miscompares;

  adder_result_accumulator #(
    .IN_W (IN_W),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_cout  (in_cout),
    .frame_len(frame_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_ovf  (out_ovf),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point: counts the vector, reports and counts a miscompare.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Offer one sample and hold it until accepted (bounded wait on in_ready).
  task automatic apply_stimulus(input logic cout, input logic [3:0] sum,
                                input logic [3:0] len);
    int waited;
    in_valid  = 1'b1;
    in_cout   = cout;
    in_sum    = sum;
    frame_len = len;
    waited    = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check_output("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Take the pending result and confirm the block reopens the next cycle.
  task automatic accept_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_output({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check_output({tag, "_reopen"},     32'(in_ready),  32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sum      = '0;
    in_cout     = 1'b0;
    frame_len   = '0;
    out_ready   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_valid", 32'(out_valid), 32'd0);
    check_output("rst_acc",   32'(out_acc),   32'd0);
    check_output("rst_count", 32'(out_count), 32'd0);
    check_output("rst_ovf",   32'(out_ovf),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("rel_ready", 32'(in_ready), 32'd1);

    // Frame of 4: 8+11+9+15 = 43
    apply_stimulus(1'b0, 4'd8,  4'd4);
    apply_stimulus(1'b0, 4'd11, 4'd4);
    apply_stimulus(1'b0, 4'd9,  4'd4);
    check_output("f1_not_yet", 32'(out_valid), 32'd0);
    apply_stimulus(1'b0, 4'd15, 4'd4);
    check_output("f1_valid", 32'(out_valid), 32'd1);
    check_output("f1_acc",   32'(out_acc),   32'd43);
    check_output("f1_count", 32'(out_count), 32'd4);
    check_output("f1_ovf",   32'(out_ovf),   32'd0);

    // Backpressure: result held, input blocked, while in_valid stays high
    in_valid  = 1'b1;
    in_cout   = 1'b0;
    in_sum    = 4'd1;
    frame_len = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_output("bp_ready", 32'(in_ready),  32'd0);
      check_output("bp_acc",   32'(out_acc),   32'd43);
      check_output("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_output("bp_reopen",  32'(in_ready), 32'd1);
    check_output("bp_cleared", 32'(out_acc),  32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("bp_next_acc",   32'(out_acc),   32'd1);
    check_output("bp_next_count", 32'(out_count), 32'd1);
    accept_result("bp");

    // frame_len=0 behaves as 1; sample {1,1111} = 31
    apply_stimulus(1'b1, 4'hF, 4'd0);
    check_output("len0_valid", 32'(out_valid), 32'd1);
    check_output("len0_acc",   32'(out_acc),   32'd31);
    check_output("len0_count", 32'(out_count), 32'd1);
    accept_result("len0");

    // Overflow: 31*3 = 93 exceeds 6 bits
    apply_stimulus(1'b1, 4'hF, 4'd3);
    apply_stimulus(1'b1, 4'hF, 4'd3);
    check_output("ovf_pre", 32'(out_ovf), 32'd0);
    apply_stimulus(1'b1, 4'hF, 4'd3);
    check_output("ovf_valid", 32'(out_valid), 32'd1);
`ifdef ACC_SATURATE_EN
    check_output("ovf_acc", 32'(out_acc), 32'd63);
`else
    check_output("ovf_acc", 32'(out_acc), 32'd29);
`endif
    check_output("ovf_flag",  32'(out_ovf),   32'd1);
    check_output("ovf_count", 32'(out_count), 32'd3);
    accept_result("ovf");
    apply_stimulus(1'b0, 4'd2, 4'd1);
    check_output("ovf_next_flag", 32'(out_ovf), 32'd0);
    check_output("ovf_next_acc",  32'(out_acc), 32'd2);
    accept_result("ovf_next");

    // Mid-frame reset after 2 of 4 samples
    apply_stimulus(1'b0, 4'd1, 4'd4);
    apply_stimulus(1'b0, 4'd1, 4'd4);
    check_output("mr_partial", 32'(out_acc), 32'd2);
    rst_n = 1'b0;
    #1;
    check_output("mr_acc",   32'(out_acc),   32'd0);
    check_output("mr_count", 32'(out_count), 32'd0);
    check_output("mr_valid", 32'(out_valid), 32'd0);
    check_output("mr_ovf",   32'(out_ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("mr_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 4'd1, 4'd4);
    check_output("mr_new_valid", 32'(out_valid), 32'd1);
    check_output("mr_new_acc",   32'(out_acc),   32'd4);
    accept_result("mr");

    // frame_len change mid-frame has no effect until the next frame
    apply_stimulus(1'b0, 4'd3, 4'd4);
    apply_stimulus(1'b0, 4'd3, 4'd2);
    check_output("fl_hold_2", 32'(out_valid), 32'd0);
    apply_stimulus(1'b0, 4'd3, 4'd2);
    check_output("fl_hold_3", 32'(out_valid), 32'd0);
    apply_stimulus(1'b0, 4'd3, 4'd2);
    check_output("fl_valid",  32'(out_valid), 32'd1);
    check_output("fl_count",  32'(out_count), 32'd4);
    check_output("fl_acc",    32'(out_acc),   32'd12);
    accept_result("fl");
    apply_stimulus(1'b0, 4'd5, 4'd2);
    check_output("fl2_hold", 32'(out_valid), 32'd0);
    apply_stimulus(1'b0, 4'd6, 4'd2);
    check_output("fl2_valid", 32'(out_valid), 32'd1);
    check_output("fl2_count", 32'(out_count), 32'd2);
    check_output("fl2_acc",   32'(out_acc),   32'd11);
    accept_result("fl2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
